encoder_prio_rr: RTL and testbench

ENCODER_PRIO_RR -- requirements
Module: encoder_prio_rr

---
 rtl/encoder_prio_rr.sv | 95 +++++++++
 tb/tb_encoder_prio_rr.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_prio_rr.sv
// encoder_prio_rr: priority encoder with a one-deep registered output stage.
// MODE 0 grants the highest-index request. MODE 1 grants round-robin from a
// pointer that moves just below the last grant. Valid/ready handshake on both
// sides; the output register refills in the same cycle it is drained.
module encoder_prio_rr #(
   parameter  int N    = 8,
   parameter  int MODE = 0,
   localparam int W    = (N > 2) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] I,
   input  logic         I_valid,
   output logic         I_ready,
   output logic [W-1:0] y,
   output logic         v,
   output logic         y_valid,
   input  logic         y_ready
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]   state;
   logic [W-1:0] grant;
   logic         any_req;
   logic         in_xfer;
   logic         out_xfer;

   assign y_valid  = (state == FULL);
   // Ready depends only on the output stage, so there is no I_valid -> I_ready path.
   assign I_ready  = !y_valid || y_ready;
   assign in_xfer  = I_valid && I_ready;
   assign out_xfer = y_valid && y_ready;
   assign any_req  = |I;

   generate
      if (MODE == 0) begin : g_fixed
         // Highest set index wins: later loop iterations override earlier ones.
         always_comb begin
            // NOTE: grant gets a default before the loop so no path leaves it
            // unassigned; otherwise a latch would be inferred.
            grant = '0;
            for (int k = 0; k < N; k++) begin
               if (I[k]) grant = W'(k);
            end
         end
      end else begin : g_rr
         logic [W-1:0] ptr;
         logic [W-1:0] idx;
         logic         found;

         // Search downward from ptr with natural W-bit wrap; first hit wins.
         always_comb begin
            grant = '0;
            found = 1'b0;
            idx   = '0;
            for (int k = 0; k < N; k++) begin
               idx = ptr - W'(k);
               if (!found && I[idx]) begin
                  grant = idx;
                  found = 1'b1;
               end
            end
         end

         // Pointer moves to one below the grant, only on an accepted non-empty input.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ptr <= W'(N - 1);
            end else if (in_xfer && any_req) begin
               ptr <= grant - 1'b1;
            end
         end
      end
   endgenerate

   // Output stage: load on input transfer, drain on output transfer, hold on stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         y     <= '0;
         v     <= 1'b0;
      end else if (in_xfer) begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, so ordering between flops never matters.
         state <= FULL;
         y     <= grant;
         v     <= any_req;
      end else if (out_xfer) begin
         state <= EMPTY;
      end
   end

endmodule

// File: tb/tb_encoder_prio_rr.sv
// Bench for encoder_prio_rr: one fixed-priority and one round-robin instance
// share stimulus; a transaction-level model predicts handshakes and grants.
module tb_encoder_prio_rr;

   logic       clk;
   logic       rst_n;
   logic [7:0] din;
   logic       din_valid;
   logic       dout_ready;

   logic       rdy0, v0, yv0;
   logic [2:0] y0;
   logic       rdy1, v1, yv1;
   logic [2:0] y1;

   int n_total = 0;
   int n_pass  = 0;

   // Model state
   int  m_ptr;
   bit  m_full;
   bit  m_v;
   bit  m_rdy;
   int  m_y0;
   int  m_y1;
   logic s_rdy0, s_rdy1;

   encoder_prio_rr #(.N(8), .MODE(0)) u_fixed (
      .clk(clk), .rst_n(rst_n), .I(din), .I_valid(din_valid), .I_ready(rdy0),
      .y(y0), .v(v0), .y_valid(yv0), .y_ready(dout_ready)
   );

   encoder_prio_rr #(.N(8), .MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .I(din), .I_valid(din_valid), .I_ready(rdy1),
      .y(y1), .v(v1), .y_valid(yv1), .y_ready(dout_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Highest requesting source, 0 if none.
   function automatic int ref_fixed(logic [7:0] r);
      for (int k = 7; k >= 0; k--) if (r[k]) return k;
      return 0;
   endfunction

   // First requesting source visiting p, p-1, ... modulo 8; 0 if none.
   function automatic int ref_rr(logic [7:0] r, int p);
      for (int s = 0; s < 8; s++) begin
         int k;
         k = (p - s + 8) % 8;
         if (r[k]) return k;
      end
      return 0;
   endfunction

   task automatic model_reset();
      m_full = 1'b0;
      m_ptr  = 7;
      m_v    = 1'b0;
      m_y0   = 0;
      m_y1   = 0;
   endtask

   // Drive one cycle from posedge+1, sample ready before the edge, update the
   // model at the edge, and return at posedge+1 with outputs settled.
   task automatic cycle(input logic [7:0] r, input bit iv, input bit yr);
      din        = r;
      din_valid  = iv;
      dout_ready = yr;
      #1;
      m_rdy  = !m_full || yr;
      s_rdy0 = rdy0;
      s_rdy1 = rdy1;
      @(posedge clk);
      if (iv && m_rdy) begin
         m_y0   = ref_fixed(r);
         m_y1   = ref_rr(r, m_ptr);
         m_v    = |r;
         m_full = 1'b1;
         if (|r) m_ptr = (m_y1 + 7) % 8;
      end else if (m_full && yr) begin
         m_full = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      din_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      din        = 8'h00;
      din_valid  = 1'b0;
      dout_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if ({rdy0, rdy1, yv0, yv1, v0, v1, y0, y1} !== {1'b1, 1'b1, 4'b0000, 3'd0, 3'd0})
         $display("FAIL reset_state: got rdy=%b%b yv=%b%b v=%b%b y=%0d/%0d, want ready=1 rest 0",
                  rdy0, rdy1, yv0, yv1, v0, v1, y0, y1);
      else n_pass++;
      rst_n = 1'b1;

      // First edge after release accepts.
      cycle(8'b0010_0110, 1'b1, 1'b1);
      n_total++;
      if ({yv0, yv1, y0, y1} !== {1'b1, 1'b1, 3'd5, 3'd5})
         $display("FAIL first_accept: got yv=%b%b y=%0d/%0d, want yv=11 y=5/5", yv0, yv1, y0, y1);
      else n_pass++;

      // Mid-cycle assert with a result held.
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({rdy0, rdy1, yv0, yv1, v0, v1, y0, y1} !== {1'b1, 1'b1, 4'b0000, 3'd0, 3'd0})
         $display("FAIL async_reset: got rdy=%b%b yv=%b%b v=%b%b y=%0d/%0d, want ready=1 rest 0",
                  rdy0, rdy1, yv0, yv1, v0, v1, y0, y1);
      else n_pass++;

      // An edge during reset registers nothing.
      din        = 8'hFF;
      din_valid  = 1'b1;
      dout_ready = 1'b0;
      @(posedge clk);
      #1;
      n_total++;
      if ({rdy0, rdy1, yv0, yv1} !== 4'b1100)
         $display("FAIL reset_hold: got rdy=%b%b yv=%b%b, want rdy=11 yv=00", rdy0, rdy1, yv0, yv1);
      else n_pass++;
      #1;
      rst_n = 1'b1;
      din_valid = 1'b0;
      model_reset();
   endtask

   task automatic test_fixed_priority();
      cycle(8'b0010_0110, 1'b1, 1'b1);
      n_total++;
      if ({yv0, v0, y0} !== {1'b1, 1'b1, 3'd5})
         $display("FAIL fixed_26: got yv=%b v=%b y=%0d, want yv=1 v=1 y=5", yv0, v0, y0);
      else n_pass++;
      cycle(8'h00, 1'b1, 1'b1);
      n_total++;
      if ({yv0, v0, y0, yv1, v1, y1} !== {1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0})
         $display("FAIL fixed_zero: got yv=%b%b v=%b%b y=%0d/%0d, want yv=11 v=00 y=0/0",
                  yv0, yv1, v0, v1, y0, y1);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      cycle(8'b0010_0110, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(8'h80, 1'b1, 1'b0);
         n_total++;
         if ({s_rdy0, yv0, y0} !== {1'b0, 1'b1, 3'd5})
            $display("FAIL stall_%0d: got ready=%b yv=%b y=%0d, want ready=0 yv=1 y=5", i, s_rdy0, yv0, y0);
         else n_pass++;
      end
      cycle(8'h80, 1'b1, 1'b1);
      n_total++;
      if ({s_rdy0, yv0, y0} !== {1'b1, 1'b1, 3'd7})
         $display("FAIL stall_release: got ready=%b yv=%b y=%0d, want ready=1 yv=1 y=7", s_rdy0, yv0, y0);
      else n_pass++;
      cycle(8'h00, 1'b0, 1'b1);
      n_total++;
      if ({yv0, yv1} !== 2'b00)
         $display("FAIL drain: got yv=%b%b, want 00", yv0, yv1);
      else n_pass++;
   endtask

   task automatic test_rr_sweep();
      int exp_seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         cycle(8'hFF, 1'b1, 1'b1);
         n_total++;
         if ({yv1, v1, y1} !== {1'b1, 1'b1, 3'(exp_seq[i])})
            $display("FAIL rr_sweep_%0d: got yv=%b v=%b y=%0d, want yv=1 v=1 y=%0d", i, yv1, v1, y1, exp_seq[i]);
         else n_pass++;
      end
   endtask

   task automatic test_rr_zero();
      logic [7:0] pat [4] = '{8'b0000_1001, 8'b0000_1001, 8'h00, 8'b0000_1001};
      int exp_y [4] = '{3, 0, 0, 3};
      bit exp_v [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(pat[i], 1'b1, 1'b1);
         n_total++;
         if ({yv1, v1, y1} !== {1'b1, exp_v[i], 3'(exp_y[i])})
            $display("FAIL rr_zero_%0d: got yv=%b v=%b y=%0d, want yv=1 v=%b y=%0d",
                     i, yv1, v1, y1, exp_v[i], exp_y[i]);
         else n_pass++;
      end
   endtask

   task automatic test_throughput();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         cycle(8'($urandom), 1'b1, 1'b1);
         n_total++;
         if ({s_rdy0, s_rdy1, yv0, yv1, v0, y0, v1, y1} !==
             {4'b1111, m_v, 3'(m_y0), m_v, 3'(m_y1)})
            $display("FAIL tput_%0d: got rdy=%b%b yv=%b%b v=%b%b y=%0d/%0d, want rdy=11 yv=11 v=%b y=%0d/%0d",
                     i, s_rdy0, s_rdy1, yv0, yv1, v0, v1, y0, y1, m_v, m_y0, m_y1);
         else n_pass++;
      end
   endtask

   task automatic test_random_handshake();
      for (int i = 0; i < 60; i++) begin
         logic [7:0] r;
         r = 8'($urandom);
         if ($urandom_range(0, 3) == 0) r = 8'h00;
         cycle(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         n_total++;
         if ({s_rdy0, s_rdy1, yv0, yv1} !== {m_rdy, m_rdy, m_full, m_full})
            $display("FAIL hs_ctrl_%0d: got rdy=%b%b yv=%b%b, want rdy=%b yv=%b",
                     i, s_rdy0, s_rdy1, yv0, yv1, m_rdy, m_full);
         else n_pass++;
         if (m_full) begin
            n_total++;
            if ({v0, y0, v1, y1} !== {m_v, 3'(m_y0), m_v, 3'(m_y1)})
               $display("FAIL hs_data_%0d: got v=%b%b y=%0d/%0d, want v=%b y=%0d/%0d",
                        i, v0, v1, y0, y1, m_v, m_y0, m_y1);
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_fixed_priority();
      test_backpressure();
      test_rr_sweep();
      test_rr_zero();
      test_throughput();
      test_random_handshake();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
